// File: rtl/fetch_stream_prefetcher_pkg.sv
// Shared constants and the in-flight read record for the instruction-line prefetcher.
package fetch_stream_prefetcher_pkg;

  localparam int FETCH_ADDR_W = 12;
  localparam int FETCH_LINE_W = 64;
  localparam int FETCH_DEPTH  = 8;
  localparam int FETCH_AHEAD  = 4;

  // The record carries FETCH_ADDR_W address bits; narrower ADDR_W values are zero-extended.
  typedef struct packed {
    logic                    valid;
    logic                    poison;
    logic [FETCH_ADDR_W-1:0] addr;
  } inflight_t;

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Shift register following each memory read through its latency, with
// per-stage poisoning on invalidate and an N-address "already in flight" match.
module fetch_inflight_tracker
  import fetch_stream_prefetcher_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int MEM_LAT = 2,
  parameter int N       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     inv_valid,
  input  logic [ADDR_W-1:0]        inv_addr,
  input  logic [N-1:0][ADDR_W-1:0] match_addr,
  output logic [N-1:0]             covered,
  output logic                     ret_valid,
  output logic [ADDR_W-1:0]        ret_addr
);

  localparam int LAST = MEM_LAT - 1;

  inflight_t               stage [MEM_LAT];
  logic [FETCH_ADDR_W-1:0] inv_key;

  assign inv_key = FETCH_ADDR_W'(inv_addr);

  // A write to a line poisons its read whether it sits in mem_addr or in any stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MEM_LAT; s++) stage[s] <= '0;
    end else begin
      stage[0].valid  <= issue_valid;
      stage[0].addr   <= FETCH_ADDR_W'(issue_addr);
      stage[0].poison <= inv_valid && (FETCH_ADDR_W'(issue_addr) == inv_key);
      for (int s = 1; s < MEM_LAT; s++) begin
        stage[s].valid  <= stage[s-1].valid;
        stage[s].addr   <= stage[s-1].addr;
        stage[s].poison <= stage[s-1].poison || (inv_valid && stage[s-1].addr == inv_key);
      end
    end
  end

  always_comb begin
    covered = '0;
    for (int n = 0; n < N; n++)
      for (int s = 0; s < MEM_LAT; s++)
        if (stage[s].valid && !stage[s].poison &&
            stage[s].addr == FETCH_ADDR_W'(match_addr[n]))
          covered[n] = 1'b1;
  end

  assign ret_valid = stage[LAST].valid && !stage[LAST].poison &&
                     !(inv_valid && stage[LAST].addr == inv_key);
  assign ret_addr  = ADDR_W'(stage[LAST].addr);

endmodule

// File: rtl/fetch_stream_prefetcher.sv
// Fully-associative instruction-line buffer that streams sequential lines ahead
// of the fetch point, plus a return-address hint line, from latency-MEM_LAT memory.
module fetch_stream_prefetcher
  import fetch_stream_prefetcher_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int LINE_W  = FETCH_LINE_W,
  parameter int DEPTH   = FETCH_DEPTH,
  parameter int LOOKUP  = 2,
  parameter int AHEAD   = FETCH_AHEAD,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [LOOKUP-1:0]        lk_valid,
  input  logic [ADDR_W*LOOKUP-1:0] lk_addr,
  output logic [LOOKUP-1:0]        lk_hit,
  output logic [LINE_W*LOOKUP-1:0] lk_data,
  input  logic                     hint_valid,
  input  logic [ADDR_W-1:0]        hint_addr,
  input  logic                     inv_valid,
  input  logic [ADDR_W-1:0]        inv_addr,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [LINE_W-1:0]        mem_rdata,
  output logic [31:0]              miss_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NCAND = AHEAD + 1;

  logic [DEPTH-1:0]             ent_valid;
  logic [ADDR_W-1:0]            ent_tag  [DEPTH];
  logic [LINE_W-1:0]            ent_data [DEPTH];
  logic [PTR_W-1:0]             ptr;
  logic                         fill_valid;
  logic [ADDR_W-1:0]            fill_addr;
  logic [LINE_W-1:0]            fill_data;
  logic                         fill_present;
  logic                         fill_write;
  logic [PTR_W-1:0]             fill_slot;
  logic [ADDR_W-1:0]            base_q;
  logic [ADDR_W-1:0]            base_now;
  logic                         any_miss;
  logic [NCAND-1:0][ADDR_W-1:0] cand;
  logic [NCAND-1:0]             trk_cov;
  logic [NCAND-1:0]             cand_cov;
  logic                         pick;
  logic [ADDR_W-1:0]            pick_addr;
  logic                         ret_valid;
  logic [ADDR_W-1:0]            ret_addr;

  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int i = 0; i < LOOKUP; i++)
      for (int e = 0; e < DEPTH; e++)
        if (lk_valid[i] && ent_valid[e] && ent_tag[e] == lk_addr[i*ADDR_W +: ADDR_W]) begin
          lk_hit[i] = 1'b1;
          lk_data[i*LINE_W +: LINE_W] = lk_data[i*LINE_W +: LINE_W] | ent_data[e];
        end
  end

  // Later assignments win: highest-index hit first, then overridden by lowest-index miss.
  always_comb begin
    base_now = base_q;
    any_miss = 1'b0;
    for (int i = 0; i < LOOKUP; i++)
      if (lk_valid[i] && lk_hit[i]) base_now = lk_addr[i*ADDR_W +: ADDR_W];
    for (int i = LOOKUP - 1; i >= 0; i--)
      if (lk_valid[i] && !lk_hit[i]) begin
        base_now = lk_addr[i*ADDR_W +: ADDR_W];
        any_miss = 1'b1;
      end
  end

  always_comb begin
    for (int k = 0; k < AHEAD; k++) cand[k] = base_now + ADDR_W'(k);
    cand[AHEAD] = hint_addr;
  end

  fetch_inflight_tracker #(
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT),
    .N      (NCAND)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(mem_req),
    .issue_addr (mem_addr),
    .inv_valid  (inv_valid),
    .inv_addr   (inv_addr),
    .match_addr (cand),
    .covered    (trk_cov),
    .ret_valid  (ret_valid),
    .ret_addr   (ret_addr)
  );

  always_comb begin
    for (int n = 0; n < NCAND; n++) begin
      cand_cov[n] = trk_cov[n] || (fill_valid && fill_addr == cand[n]) ||
                    (mem_req && mem_addr == cand[n]);
      for (int e = 0; e < DEPTH; e++)
        if (ent_valid[e] && ent_tag[e] == cand[n]) cand_cov[n] = 1'b1;
    end
  end

  // Nearest sequential line wins; the hint only fills an otherwise idle slot.
  always_comb begin
    pick      = 1'b0;
    pick_addr = mem_addr;
    if (hint_valid && !cand_cov[AHEAD]) begin
      pick      = 1'b1;
      pick_addr = hint_addr;
    end
    for (int k = AHEAD - 1; k >= 0; k--)
      if (!cand_cov[k]) begin
        pick      = 1'b1;
        pick_addr = cand[k];
      end
    if (!enable) pick = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      base_q     <= '0;
      miss_count <= '0;
    end else begin
      mem_req <= pick;
      if (pick) mem_addr <= pick_addr;
      base_q <= base_now;
      if (any_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end

  always_comb begin
    fill_present = 1'b0;
    fill_slot    = ptr;
    for (int e = 0; e < DEPTH; e++)
      if (ent_valid[e] && ent_tag[e] == fill_addr) begin
        fill_present = 1'b1;
        fill_slot    = PTR_W'(e);
      end
  end

  assign fill_write = fill_valid && !(inv_valid && inv_addr == fill_addr);

  // Invalidation is applied before the fill so a fill into an invalidated slot survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid  <= '0;
      ptr        <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        if (inv_valid && ent_valid[e] && ent_tag[e] == inv_addr) ent_valid[e] <= 1'b0;
      if (fill_write) begin
        ent_valid[fill_slot] <= 1'b1;
        ent_tag[fill_slot]   <= fill_addr;
        ent_data[fill_slot]  <= fill_data;
        if (!fill_present) ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
      fill_valid <= ret_valid;
      fill_addr  <= ret_addr;
      if (ret_valid) fill_data <= mem_rdata;
    end
  end

endmodule
